// File: rtl/instr_aligner_if.sv
// Handshake bundle between the fetch FIFO / decode stage and the instruction aligner.
// Member names keep the aligner-side direction suffixes so that they read the same as the block's pin list.
interface instr_aligner_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            word_valid_i;
  logic [XLEN-1:0] word_i;
  logic            word_ready_o;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            is_compressed_o;

  // Aligner side: consumes fetch words, produces aligned instructions.
  modport slave (
    input  flush_i,
    input  redirect_pc_i,
    input  word_valid_i,
    input  word_i,
    input  instr_ready_i,
    output word_ready_o,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    output is_compressed_o
  );

  // Environment side: fetch FIFO plus decode.
  modport master (
    output flush_i,
    output redirect_pc_i,
    output word_valid_i,
    output word_i,
    output instr_ready_i,
    input  word_ready_o,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    input  is_compressed_o
  );
endinterface

// File: rtl/instr_aligner.sv
// Instruction aligner: splits 32-bit fetch words into 16/32-bit instructions,
// stitches instructions that straddle two words, and tracks the PC of each one.
// Results go through a single registered output slot with a valid/ready handshake.
module instr_aligner #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  instr_aligner_if.slave  bus
);

  localparam int PW = 16;

  // Held upper parcel, pending skip of a lower parcel, and next-instruction PC.
  logic            hw_valid_q;
  logic [PW-1:0]   hw_q;
  logic            skip_lo_q;
  logic [XLEN-1:0] pc_q;

  // Output slot.
  logic            out_valid_q;
  logic [XLEN-1:0] out_instr_q;
  logic [XLEN-1:0] out_pc_q;
  logic            out_comp_q;

  // Candidate decisions for this cycle.
  logic            adv;
  logic            emit;
  logic [XLEN-1:0] emit_instr;
  logic            emit_comp;
  logic            consume;
  logic            hw_valid_d;
  logic [PW-1:0]   hw_d;
  logic            skip_lo_d;
  logic [XLEN-1:0] pc_step;
  logic            hw_comp;
  logic            lo_comp;
  logic [PW-1:0]   word_lo;
  logic [PW-1:0]   word_hi;

  assign word_lo = bus.word_i[PW-1:0];
  assign word_hi = bus.word_i[XLEN-1:PW];
  assign hw_comp = (hw_q[1:0] != 2'b11);
  assign lo_comp = (word_lo[1:0] != 2'b11);

  // The output slot can take a new instruction when it is empty or being drained.
  assign adv = !out_valid_q || bus.instr_ready_i;

  // Pick what to emit and how the held-parcel state moves, in priority order.
  always_comb begin
    emit       = 1'b0;
    emit_instr = '0;
    emit_comp  = 1'b0;
    consume    = 1'b0;
    hw_valid_d = hw_valid_q;
    hw_d       = hw_q;
    skip_lo_d  = skip_lo_q;
    if (hw_valid_q) begin
      if (hw_comp) begin
        // Held parcel is a complete compressed instruction; no word needed.
        emit       = 1'b1;
        emit_instr = {{(XLEN-PW){1'b0}}, hw_q};
        emit_comp  = 1'b1;
        hw_valid_d = 1'b0;
      end else if (bus.word_valid_i) begin
        // Held parcel is the low half of a straddling 32-bit instruction.
        emit       = 1'b1;
        emit_instr = {word_lo, hw_q};
        emit_comp  = 1'b0;
        consume    = 1'b1;
        hw_d       = word_hi;
      end
    end else if (bus.word_valid_i) begin
      consume = 1'b1;
      hw_d    = word_hi;
      if (skip_lo_q) begin
        // Redirect landed mid-word: drop the lower parcel, keep the upper.
        hw_valid_d = 1'b1;
        skip_lo_d  = 1'b0;
      end else if (lo_comp) begin
        emit       = 1'b1;
        emit_instr = {{(XLEN-PW){1'b0}}, word_lo};
        emit_comp  = 1'b1;
        hw_valid_d = 1'b1;
      end else begin
        emit       = 1'b1;
        emit_instr = bus.word_i;
        emit_comp  = 1'b0;
      end
    end
  end

  assign pc_step = emit_comp ? XLEN'(2) : XLEN'(4);

  // The FIFO pop is suppressed in reset, on a redirect and while the output is blocked.
  assign bus.word_ready_o = rst_ni && !bus.flush_i && adv && consume;

  // Held parcel, skip flag and PC tracking; a redirect discards everything held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_valid_q <= 1'b0;
      hw_q       <= '0;
      skip_lo_q  <= 1'b0;
      pc_q       <= PC_RESET;
    end else if (bus.flush_i) begin
      hw_valid_q <= 1'b0;
      skip_lo_q  <= bus.redirect_pc_i[1];
      pc_q       <= bus.redirect_pc_i & ~XLEN'(1);
    end else if (adv) begin
      hw_valid_q <= hw_valid_d;
      hw_q       <= hw_d;
      skip_lo_q  <= skip_lo_d;
      if (emit) begin
        pc_q <= pc_q + pc_step;
      end
    end
  end

  // Output slot: loads on emit, empties when drained with nothing new, holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_comp_q  <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= emit;
      if (emit) begin
        out_instr_q <= emit_instr;
        out_pc_q    <= pc_q;
        out_comp_q  <= emit_comp;
      end
    end
  end

  assign bus.instr_valid_o   = out_valid_q;
  assign bus.instr_o         = out_instr_q;
  assign bus.instr_pc_o      = out_pc_q;
  assign bus.is_compressed_o = out_comp_q;

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: a parcel-stream model predicts the
// instruction sequence, and directed tests pin exact values and timing.
module tb_instr_aligner;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_aligner_if #(.XLEN(32)) bus ();

  instr_aligner #(.XLEN(32), .PC_RESET(PC_RESET)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        log_q[$];
  logic [15:0] parcel_q[$];
  logic [31:0] model_pc;
  logic        model_skip;
  int          total = 0;
  int          bad = 0;
  int          words_taken = 0;
  logic        hold_prev = 1'b0;
  rec_t        held;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Turn the buffered halfword stream into whole instructions with their PCs.
  task automatic model_parse();
    rec_t r;
    while (parcel_q.size() > 0) begin
      if (parcel_q[0][1:0] != 2'b11) begin
        r.instr = {16'h0000, parcel_q[0]};
        r.pc    = model_pc;
        r.comp  = 1'b1;
        exp_q.push_back(r);
        model_pc = model_pc + 32'd2;
        void'(parcel_q.pop_front());
      end else if (parcel_q.size() >= 2) begin
        r.instr = {parcel_q[1], parcel_q[0]};
        r.pc    = model_pc;
        r.comp  = 1'b0;
        exp_q.push_back(r);
        model_pc = model_pc + 32'd4;
        void'(parcel_q.pop_front());
        void'(parcel_q.pop_front());
      end else begin
        break;
      end
    end
  endtask

  // Compare process: on each falling edge, look at what the next rising edge will transfer.
  always @(negedge clk) begin
    rec_t cur;
    rec_t e;
    cur.instr = bus.instr_o;
    cur.pc    = bus.instr_pc_o;
    cur.comp  = bus.is_compressed_o;
    if (!rst_n) begin
      check_bit("rst_valid", bus.instr_valid_o, 1'b0);
      check_output("rst_instr", bus.instr_o, 32'h0);
      check_output("rst_pc", bus.instr_pc_o, 32'h0);
      check_bit("rst_comp", bus.is_compressed_o, 1'b0);
      check_bit("rst_word_ready", bus.word_ready_o, 1'b0);
      exp_q.delete();
      parcel_q.delete();
      model_pc   = PC_RESET;
      model_skip = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      if (hold_prev) begin
        check_bit("hold_valid", bus.instr_valid_o, 1'b1);
        check_output("hold_instr", bus.instr_o, held.instr);
        check_output("hold_pc", bus.instr_pc_o, held.pc);
        check_bit("hold_comp", bus.is_compressed_o, held.comp);
      end
      if (bus.instr_valid_o && !bus.instr_ready_i)
        check_bit("stall_word_ready", bus.word_ready_o, 1'b0);
      if (!bus.word_valid_i)
        check_bit("no_word_ready", bus.word_ready_o, 1'b0);
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        log_q.push_back(cur);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_instr: got %h at pc %h, model expects nothing", cur.instr, cur.pc);
        end else begin
          e = exp_q.pop_front();
          check_output("model_instr", cur.instr, e.instr);
          check_output("model_pc", cur.pc, e.pc);
          check_bit("model_comp", cur.comp, e.comp);
        end
      end
      if (bus.flush_i) begin
        check_bit("flush_word_ready", bus.word_ready_o, 1'b0);
        exp_q.delete();
        parcel_q.delete();
        model_pc   = bus.redirect_pc_i & ~32'h1;
        model_skip = bus.redirect_pc_i[1];
        hold_prev  = 1'b0;
      end else begin
        hold_prev = bus.instr_valid_o && !bus.instr_ready_i;
        held      = cur;
        if (bus.word_valid_i && bus.word_ready_o) begin
          words_taken++;
          if (!model_skip) parcel_q.push_back(bus.word_i[15:0]);
          model_skip = 1'b0;
          parcel_q.push_back(bus.word_i[31:16]);
          model_parse();
        end
      end
    end
  end

  // Offer one fetch word until it is popped, then withdraw it; returns at rising edge + 1.
  task automatic apply_stimulus(input logic [31:0] w);
    int n = 0;
    bus.word_valid_i = 1'b1;
    bus.word_i       = w;
    @(negedge clk);
    while (!bus.word_ready_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!bus.word_ready_o) begin
      total++;
      bad++;
      $display("[TB] FAIL word_timeout: word %h not consumed, want consumed within 40 cycles", w);
    end
    @(posedge clk);
    #1;
    bus.word_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input int idx, input logic [31:0] instr, input logic [31:0] pc, input logic comp);
    if (idx >= log_q.size()) begin
      total++;
      bad++;
      $display("[TB] FAIL log_missing: entry %0d absent (have %0d), want %h", idx, log_q.size(), instr);
    end else begin
      check_output("log_instr", log_q[idx].instr, instr);
      check_output("log_pc", log_q[idx].pc, pc);
      check_bit("log_comp", log_q[idx].comp, comp);
    end
  endtask

  task automatic start_test();
    log_q.delete();
    words_taken = 0;
  endtask

  task automatic end_test(input int n_instr, input int n_words);
    check_output("log_count", 32'(log_q.size()), 32'(n_instr));
    check_output("words_taken", 32'(words_taken), 32'(n_words));
    check_output("model_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.flush_i       = 1'b1;
    bus.redirect_pc_i = pc;
    bus.word_valid_i  = 1'b1;
    bus.word_i        = 32'hDEAD_BEEF;
    idle(1);
    bus.flush_i      = 1'b0;
    bus.word_valid_i = 1'b0;
    #1;
    check_bit("flush_clears_valid", bus.instr_valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.flush_i       = 1'b0;
    bus.redirect_pc_i = '0;
    bus.word_valid_i  = 1'b0;
    bus.word_i        = '0;
    bus.instr_ready_i = 1'b1;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("reset_valid_now", bus.instr_valid_o, 1'b0);
    check_bit("reset_word_ready_now", bus.word_ready_o, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] two full-width instructions");
    start_test();
    apply_stimulus(32'h0000_0013);
    check_bit("t1_valid", bus.instr_valid_o, 1'b1);
    check_output("t1_first", bus.instr_o, 32'h0000_0013);
    apply_stimulus(32'h0010_0093);
    idle(3);
    check_log(0, 32'h0000_0013, 32'h0, 1'b0);
    check_log(1, 32'h0010_0093, 32'h4, 1'b0);
    end_test(2, 2);

    $display("[TB] two compressed instructions in one word");
    start_test();
    apply_stimulus(32'h4505_4501);
    #1;
    check_bit("t2_valid", bus.instr_valid_o, 1'b1);
    check_output("t2_first", bus.instr_o, 32'h0000_4501);
    check_bit("t2_no_pop", bus.word_ready_o, 1'b0);
    idle(3);
    check_log(0, 32'h0000_4501, 32'h8, 1'b1);
    check_log(1, 32'h0000_4505, 32'hA, 1'b1);
    end_test(2, 1);

    $display("[TB] straddling instruction");
    start_test();
    apply_stimulus(32'h0513_4501);
    apply_stimulus(32'h0000_0010);
    idle(3);
    check_log(0, 32'h0000_4501, 32'hC, 1'b1);
    check_log(1, 32'h0010_0513, 32'hE, 1'b0);
    check_log(2, 32'h0000_0000, 32'h12, 1'b1);
    end_test(3, 2);

    $display("[TB] redirect to a halfword address");
    start_test();
    redirect(32'h0000_0102);
    apply_stimulus(32'h4585_FFFF);
    #1;
    check_bit("t4_bubble", bus.instr_valid_o, 1'b0);
    idle(1);
    check_bit("t4_valid", bus.instr_valid_o, 1'b1);
    check_output("t4_instr", bus.instr_o, 32'h0000_4585);
    check_output("t4_pc", bus.instr_pc_o, 32'h0000_0102);
    check_bit("t4_comp", bus.is_compressed_o, 1'b1);
    idle(2);
    check_log(0, 32'h0000_4585, 32'h102, 1'b1);
    end_test(1, 1);

    $display("[TB] decode back-pressure");
    start_test();
    bus.instr_ready_i = 1'b0;
    apply_stimulus(32'h0000_0013);
    bus.word_valid_i = 1'b1;
    bus.word_i       = 32'h0020_0113;
    repeat (3) begin
      @(negedge clk);
      check_bit("t5_stall_ready", bus.word_ready_o, 1'b0);
      check_output("t5_hold_instr", bus.instr_o, 32'h0000_0013);
    end
    @(posedge clk);
    #1;
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    check_bit("t5_resume_ready", bus.word_ready_o, 1'b1);
    @(posedge clk);
    #1;
    bus.word_valid_i = 1'b0;
    idle(3);
    check_log(0, 32'h0000_0013, 32'h104, 1'b0);
    check_log(1, 32'h0020_0113, 32'h108, 1'b0);
    end_test(2, 2);

    $display("[TB] PC wrap-around");
    start_test();
    redirect(32'hFFFF_FFFC);
    apply_stimulus(32'h4505_4501);
    apply_stimulus(32'h0000_0013);
    idle(3);
    check_log(0, 32'h0000_4501, 32'hFFFF_FFFC, 1'b1);
    check_log(1, 32'h0000_4505, 32'hFFFF_FFFE, 1'b1);
    check_log(2, 32'h0000_0013, 32'h0000_0000, 1'b0);
    end_test(3, 2);

    $display("[TB] reset mid-instruction");
    start_test();
    bus.instr_ready_i = 1'b0;
    apply_stimulus(32'h4505_4501);
    check_bit("t7_pending", bus.instr_valid_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("t7_valid", bus.instr_valid_o, 1'b0);
    check_output("t7_instr", bus.instr_o, 32'h0);
    check_output("t7_pc", bus.instr_pc_o, 32'h0);
    check_bit("t7_comp", bus.is_compressed_o, 1'b0);
    check_bit("t7_word_ready", bus.word_ready_o, 1'b0);
    idle(2);
    rst_n = 1'b1;
    bus.instr_ready_i = 1'b1;
    start_test();
    apply_stimulus(32'h0000_0013);
    idle(3);
    check_log(0, 32'h0000_0013, PC_RESET, 1'b0);
    end_test(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
